// File: rtl/logic_pkg.sv
// Shared constants for the bitwise logic unit and its arbiter.
package logic_pkg;
    localparam int DW = 32;

    typedef logic [1:0] op_t;

    localparam op_t OP_AND = 2'b00;
    localparam op_t OP_OR  = 2'b01;
    localparam op_t OP_XOR = 2'b10;
    localparam op_t OP_NOR = 2'b11;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          zero;
    } logic_res_t;
endpackage

// File: rtl/logic32.sv
// Combinational 32-bit bitwise unit: four gate arrays feeding a 4:1 select.
module logic32
    import logic_pkg::*;
(
    input  op_t           op,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic [DW-1:0] res
);
    logic [DW-1:0] and_v, or_v, xor_v, nor_v;

    genvar g;
    generate
        for (g = 0; g < DW; g++) begin : g_bit
            assign and_v[g] = a[g] & b[g];
            assign or_v[g]  = a[g] | b[g];
            assign xor_v[g] = a[g] ^ b[g];
            assign nor_v[g] = ~(a[g] | b[g]);
        end
    endgenerate

    always_comb begin
        res = and_v;
        case (op)
            OP_AND:  res = and_v;
            OP_OR:   res = or_v;
            OP_XOR:  res = xor_v;
            OP_NOR:  res = nor_v;
            default: res = and_v;
        endcase
    end
endmodule

// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter sharing one logic32 among NREQ requesters; one
// registered result slot returned on a valid/ready channel tagged by ID.
module logic_unit_arbiter
    import logic_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [2*NREQ-1:0] req_op,
    input  logic [DW*NREQ-1:0] req_a,
    input  logic [DW*NREQ-1:0] req_b,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DW-1:0]     resp_data,
    output logic              resp_zero,
    output logic [IDW-1:0]    resp_id
);
    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] grant_idx;
    logic [IDW-1:0] next_ptr;
    logic           hit;
    logic           grant;
    logic           slot_free;
    int             cand;

    op_t            sel_op;
    logic [DW-1:0]  sel_a;
    logic [DW-1:0]  sel_b;
    logic [DW-1:0]  alu_res;

    // Search starts at rr_ptr and wraps; the first valid requester wins.
    always_comb begin
        grant_idx = '0;
        hit       = 1'b0;
        cand      = 0;
        for (int k = 0; k < NREQ; k++) begin
            cand = (int'(rr_ptr) + k) % NREQ;
            if (!hit && req_valid[cand]) begin
                hit       = 1'b1;
                grant_idx = IDW'(cand);
            end
        end
    end

    assign slot_free = !resp_valid || resp_ready;
    // rst_n gate keeps req_ready low for the whole reset window.
    assign grant     = hit && slot_free && rst_n;

    always_comb begin
        req_ready = '0;
        if (grant)
            req_ready[grant_idx] = 1'b1;
    end

    always_comb begin
        sel_op = OP_AND;
        sel_a  = '0;
        sel_b  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (IDW'(i) == grant_idx) begin
                sel_op = req_op[2*i +: 2];
                sel_a  = req_a[DW*i +: DW];
                sel_b  = req_b[DW*i +: DW];
            end
        end
    end

    logic32 u_logic (
        .op  (sel_op),
        .a   (sel_a),
        .b   (sel_b),
        .res (alu_res)
    );

    assign next_ptr = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_valid <= 1'b0;
            resp_data  <= '0;
            resp_zero  <= 1'b0;
            resp_id    <= '0;
            rr_ptr     <= '0;
        end else if (grant) begin
            // Covers both an empty slot and consume-and-refill in one cycle.
            resp_valid <= 1'b1;
            resp_data  <= alu_res;
            resp_zero  <= (alu_res == '0);
            resp_id    <= grant_idx;
            rr_ptr     <= next_ptr;
        end else if (resp_ready) begin
            resp_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Self-checking bench: behavioural model checked every negedge, plus
// directed literal checks that pin the model.
module tb_logic_unit_arbiter;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [2*N-1:0] req_op;
    logic [32*N-1:0] req_a;
    logic [32*N-1:0] req_b;
    logic           resp_valid;
    logic           resp_ready;
    logic [31:0]    resp_data;
    logic           resp_zero;
    logic [1:0]     resp_id;

    int n_cmp = 0;
    int n_bad = 0;

    // model state
    bit          m_valid;
    logic [31:0] m_data;
    bit          m_zero;
    int          m_id;
    int          m_ptr;

    logic_unit_arbiter #(.NREQ(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_zero  (resp_zero),
        .resp_id    (resp_id)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] op_fn(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            2'b00:   return a & b;
            2'b01:   return a | b;
            2'b10:   return a ^ b;
            default: return ~(a | b);
        endcase
    endfunction

    // Compare + model advance; inputs are stable from posedge+2 to the next posedge.
    always @(negedge clk) begin
        int g;
        logic [N-1:0] exp_rdy;
        if (!rst_n) begin
            chk("rst_req_ready", 32'(req_ready), 32'd0);
            chk("rst_resp_valid", 32'(resp_valid), 32'd0);
            chk("rst_resp_data", resp_data, 32'd0);
            chk("rst_resp_id", 32'(resp_id), 32'd0);
            m_valid = 0; m_data = '0; m_zero = 0; m_id = 0; m_ptr = 0;
        end else begin
            g = -1;
            if (!m_valid || resp_ready)
                for (int k = 0; k < N; k++)
                    if (g < 0 && req_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
            exp_rdy = '0;
            if (g >= 0) exp_rdy[g] = 1'b1;
            chk("req_ready", 32'(req_ready), 32'(exp_rdy));
            chk("resp_valid", 32'(resp_valid), 32'(m_valid));
            if (m_valid) begin
                chk("resp_data", resp_data, m_data);
                chk("resp_zero", 32'(resp_zero), 32'(m_zero));
                chk("resp_id", 32'(resp_id), 32'(m_id));
            end
            if (g >= 0) begin
                m_valid = 1;
                m_data  = op_fn(req_op[2*g +: 2], req_a[32*g +: 32], req_b[32*g +: 32]);
                m_zero  = (m_data == 0);
                m_id    = g;
                m_ptr   = (g + 1) % N;
            end else if (resp_ready) begin
                m_valid = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_req(input int i, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        req_op[2*i +: 2] = op;
        req_a[32*i +: 32] = a;
        req_b[32*i +: 32] = b;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        req_valid = '1;
        req_op = '0; req_a = '0; req_b = '0;
        resp_ready = 1'b1;
        for (int i = 0; i < N; i++) set_req(i, 2'b01, 32'h1 << i, 32'h100 << i);

        // Reset with all requesters valid
        tick();
        #1;
        chk("lit_rst_ready", 32'(req_ready), 32'd0);
        chk("lit_rst_valid", 32'(resp_valid), 32'd0);
        chk("lit_rst_data", resp_data, 32'd0);
        tick();

        // Single XOR
        rst_n = 1'b1;
        req_valid = 4'b0001;
        set_req(0, 2'b10, 32'hFFFF0000, 32'h0F0F0F0F);
        tick();
        chk("lit_xor_data", resp_data, 32'hF0F00F0F);
        chk("lit_xor_id", 32'(resp_id), 32'd0);
        chk("lit_xor_zero", 32'(resp_zero), 32'd0);
        chk("lit_xor_valid", 32'(resp_valid), 32'd1);
        req_valid = '0;
        tick();

        // Round-robin from a fresh pointer
        do_reset();
        req_valid = '1;
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("lit_rr_id", 32'(resp_id), 32'(k % 4));
            chk("lit_rr_valid", 32'(resp_valid), 32'd1);
        end

        // Backpressure
        do_reset();
        resp_ready = 1'b0;
        tick();
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("lit_bp_ready", 32'(req_ready), 32'd0);
            chk("lit_bp_id", 32'(resp_id), 32'd0);
            tick();
        end
        resp_ready = 1'b1;
        #1;
        chk("lit_bp_release_ready", 32'(req_ready), 32'b0010);
        tick();
        chk("lit_bp_next_id", 32'(resp_id), 32'd1);
        chk("lit_bp_next_valid", 32'(resp_valid), 32'd1);

        // Zero flag
        req_valid = 4'b0001;
        set_req(0, 2'b10, 32'h12345678, 32'h12345678);
        tick();
        chk("lit_zero_xor_data", resp_data, 32'd0);
        chk("lit_zero_xor_flag", 32'(resp_zero), 32'd1);
        req_valid = 4'b0100;
        set_req(2, 2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF);
        tick();
        chk("lit_zero_nor_data", resp_data, 32'd0);
        chk("lit_zero_nor_flag", 32'(resp_zero), 32'd1);
        chk("lit_zero_nor_id", 32'(resp_id), 32'd2);

        // Mid-operation reset with rr_ptr=2 and a held result
        do_reset();
        req_valid = 4'b0010;
        resp_ready = 1'b0;
        tick();
        chk("lit_mid_valid", 32'(resp_valid), 32'd1);
        chk("lit_mid_id", 32'(resp_id), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("lit_mid_rst_valid", 32'(resp_valid), 32'd0);
        chk("lit_mid_rst_data", resp_data, 32'd0);
        chk("lit_mid_rst_id", 32'(resp_id), 32'd0);
        chk("lit_mid_rst_ready", 32'(req_ready), 32'd0);
        tick();
        rst_n = 1'b1;
        req_valid = 4'b1001;
        resp_ready = 1'b1;
        #1;
        chk("lit_mid_post_ready", 32'(req_ready), 32'b0001);
        tick();
        chk("lit_mid_post_id", 32'(resp_id), 32'd0);

        // Randomized traffic against the model
        for (int c = 0; c < 600; c++) begin
            rst_n = ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
            req_valid = N'($urandom);
            resp_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++) begin
                logic [31:0] a;
                a = $urandom;
                set_req(i, 2'($urandom), a, ($urandom_range(0, 7) == 0) ? a : $urandom);
            end
            tick();
        end

        rst_n = 1'b1;
        req_valid = '0;
        tick();
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
